rom_responder: RTL and testbench
================================

// Module: rom_responder
// PURPOSE
//  Memory-side end of the fetch port: accepts rom_en/rom_addr/rom_write_en/rom_write_data
//  from the PC stage and returns rom_read_data one cycle after the address is presented.
//  Backs the port with a slow ready-handshaked memory, holding a one-word hit buffer.
//  On a miss or write it raises rom_stall, which the stall unit turns into stall_pc.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles waiting for mem_ready before aborting with bus_err
//  NOP_WORD  32'h0000_0000  word returned on an aborted fetch
// PORTS
//  clk             in   1    clock, all state on posedge
//  rst             in   1    reset, asynchronous, active-low
//  rom_en          in   1    port enable from PC stage
//  rom_write_en    in   `MEM_SEL_BUS  byte write lanes; 0 = read
//  rom_addr        in   `ADDR_BUS     byte address (bits [1:0] ignored)
//  rom_write_data  in   `DATA_BUS     write data
//  rom_read_data   out  `DATA_BUS     instruction word for the captured address
//  rom_stall       out  1    request not yet serviced; hold rom_addr/rom_en stable
//  bus_err         out  1    one-cycle pulse on timeout abort
//  mem_req         out  1    backing request, held until mem_ready
//  mem_we          out  `MEM_SEL_BUS  backing byte write lanes
//  mem_addr        out  `ADDR_BUS     word-aligned backing address ([1:0]=0)
//  mem_wdata       out  `DATA_BUS     backing write data
//  mem_ready       in   1    backing accepts write / returns mem_rdata this cycle
//  mem_rdata       in   `DATA_BUS     backing read data, valid with mem_ready
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; req_valid=0; buffer valid=0; rom_read_data=0;
//    rom_stall=0; bus_err=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; timeout count=0.
//  - Capture: on posedge with rom_en=1 and rom_stall=0, register req_addr/req_we/req_wdata,
//    req_valid<=1. rom_en=0 at an edge with rom_stall=0 -> req_valid<=0.
//  - rom_stall is a function of registers only (state, req_*, buffer); no combinational
//    path from rom_addr/rom_en to rom_stall (the PC next-address mux depends on it).
//  - Read hit (req_valid, req_we=0, buffer valid, tag==req_addr[31:2]) in IDLE:
//    rom_stall=0, rom_read_data=buffer data. Latency: address at edge N, data after N.
//  - Read miss: rom_stall=1 same cycle; IDLE->FETCH: mem_req=1, mem_we=0,
//    mem_addr={req_addr[31:2],2'b00}. On mem_ready: buffer<= {tag,mem_rdata,valid},
//    mem_req<=0, ->IDLE; next cycle is a hit, rom_stall drops.
//  - Write (req_we!=0): rom_stall=1; IDLE->WRITE: mem_req=1, mem_we=req_we,
//    mem_wdata=req_wdata. On mem_ready: if buffer tag matches, merge enabled bytes into
//    buffer (write-through), ->IDLE; then rom_stall=0 and no new backing request for it
//    (req marked done). rom_read_data after a write = buffer word if tag matches, else hold.
//  - Timeout: counter runs in FETCH/WRITE, clears on entry. At TIMEOUT_CYCLES without
//    mem_ready: mem_req<=0, bus_err pulse 1 cycle, FETCH returns NOP_WORD (buffer not
//    filled, req marked done), ->IDLE.
//  - mem_ready while IDLE is ignored. req_* frozen while rom_stall=1.
//  - Reset mid-FETCH/WRITE: mem_req drops immediately (async); transaction abandoned.
//  - A hit buffer word is never reused across reset.
// STRUCTURE
//  - Widths from bus.v (`ADDR_BUS, `DATA_BUS, `MEM_SEL_BUS); add romdef.v holding
//    `ROM_ST_IDLE/`ROM_ST_FETCH/`ROM_ST_WRITE (2-bit) and `ROM_NOP_WORD.
//  - One sub-module: rom_line_buf (tag/data/valid regs, hit compare, byte-lane merge).
//  - FSM, capture regs and timeout counter live in rom_responder.
// TESTING
//  1. Miss then hit: rom_en=1, addr 0xBFC00000, mem_ready after 3 cycles with
//     0x3C080001 -> rom_stall=1 for 4 cycles, mem_addr=0xBFC00000, then data 0x3C080001.
//  2. Repeat same addr (stalled PC) -> rom_stall=0, no mem_req, data 0x3C080001 in 1 cycle.
//  3. Write rom_write_en=4'b0011, data 0x0000ABCD to buffered addr -> mem_we=0011,
//     buffer word becomes 0x3C08ABCD; following read hit returns 0x3C08ABCD.
//  4. mem_ready never asserted, TIMEOUT_CYCLES=8 -> bus_err pulses at cycle 8,
//     rom_read_data=0x00000000, rom_stall low next cycle, mem_req low.
//  5. Assert rst low mid-FETCH -> mem_req, rom_stall, rom_read_data all 0 without clock;
//     after release same addr misses again (buffer invalidated).
//  6. rom_en=0 for 5 cycles -> no mem_req, rom_stall=0, rom_read_data holds.

Source files
------------

// File: rtl/rom_responder_pkg.sv
// Shared widths, FSM state encoding and byte-merge helper for the fetch-port responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rom_responder_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;
  localparam int TAG_W  = ADDR_W - 2;

  localparam logic [DATA_W-1:0] ROM_NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ROM_ST_IDLE  = 2'b00,
    ROM_ST_FETCH = 2'b01,
    ROM_ST_WRITE = 2'b10
  } rom_st_e;

  // Replace the byte lanes of old_w selected by be with the same lanes of new_w.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [SEL_W-1:0]  be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < SEL_W; i++) begin
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rom_line_buf.sv
// One-word hit buffer: tag/data/valid registers, hit compare and write-through byte merge.
// Latency: hit_o/data_o combinational from registers; fill/merge take effect next cycle.
// Backpressure: none, fill_i and wr_i are single-cycle strobes from the responder FSM.
// Ports: tag_i lookup/fill tag; fill_i/fill_data_i load a fresh word; wr_i/wr_be_i/wr_data_i
//        merge a completed write when the tag matches; hit_o, data_o, merged_o (preview).
module rom_line_buf
  import rom_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              fill_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              wr_i,
  input  logic [SEL_W-1:0]  wr_be_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] merged_o
);

  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign hit_o    = valid_q && (tag_q == tag_i);
  assign data_o   = data_q;
  assign merged_o = merge_bytes(data_q, wr_data_i, wr_be_i);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_i) begin
      valid_d = 1'b1;
      tag_d   = tag_i;
      data_d  = fill_data_i;
    end else if (wr_i && hit_o) begin
      // Write-through: keep the buffered copy coherent with the backing store.
      data_d = merged_o;
    end
  end

  // Async clear guarantees a buffered word never survives a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/rom_responder.sv
// Fetch-port memory responder: captures PC-stage requests, serves hits from a one-word
// buffer, forwards misses/writes to a ready-handshaked backing memory with timeout abort.
// Latency: hit data the cycle after capture; miss/write stall until mem_ready or timeout.
// Backpressure: rom_stall (registers only) holds the PC stage; mem_req held until mem_ready.
// Ports: rom_* PC-stage side, mem_* backing side, bus_err one-cycle abort pulse.
module rom_responder
  import rom_responder_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] NOP_WORD       = ROM_NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_en,
  input  logic [SEL_W-1:0]  rom_write_en,
  input  logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_write_data,
  output logic [DATA_W-1:0] rom_read_data,
  output logic              rom_stall,
  output logic              bus_err,
  output logic              mem_req,
  output logic [SEL_W-1:0]  mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  rom_st_e           state_q, state_d;
  logic              req_valid_q, req_valid_d;
  logic              req_done_q, req_done_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;
  logic [SEL_W-1:0]  req_we_q, req_we_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              bus_err_q, bus_err_d;
  logic              mem_req_q, mem_req_d;
  logic [SEL_W-1:0]  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              buf_hit, buf_fill, buf_wr;
  logic [DATA_W-1:0] buf_data, buf_merged;
  logic              is_write, read_hit, need_fetch, need_write;
  logic              addr_lsb_unused;

  // Instruction fetches are word granular; the byte offset carries no information.
  assign addr_lsb_unused = ^rom_addr[1:0];

  rom_line_buf u_line_buf (
    .clk         (clk),
    .rst         (rst),
    .tag_i       (req_tag_q),
    .fill_i      (buf_fill),
    .fill_data_i (mem_rdata),
    .wr_i        (buf_wr),
    .wr_be_i     (req_we_q),
    .wr_data_i   (req_wdata_q),
    .hit_o       (buf_hit),
    .data_o      (buf_data),
    .merged_o    (buf_merged)
  );

  // Everything below depends only on registers, so rom_stall has no path from rom_addr/rom_en.
  assign is_write   = |req_we_q;
  assign read_hit   = req_valid_q && !is_write && buf_hit;
  assign need_fetch = req_valid_q && !is_write && !buf_hit && !req_done_q;
  assign need_write = req_valid_q && is_write && !req_done_q;

  assign rom_stall     = (state_q != ROM_ST_IDLE) || need_fetch || need_write;
  assign rom_read_data = (state_q == ROM_ST_IDLE && read_hit) ? buf_data : rd_q;
  assign bus_err       = bus_err_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_done_d  = req_done_q;
    req_tag_d   = req_tag_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    cnt_d       = cnt_q;
    rd_d        = rom_read_data;  // remember whatever was last presented
    bus_err_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    buf_fill    = 1'b0;
    buf_wr      = 1'b0;

    case (state_q)
      ROM_ST_IDLE: begin
        // mem_ready is deliberately not looked at here.
        if (need_fetch) begin
          state_d    = ROM_ST_FETCH;
          mem_req_d  = 1'b1;
          mem_we_d   = '0;
          mem_addr_d = {req_tag_q, 2'b00};
          cnt_d      = '0;
        end else if (need_write) begin
          state_d     = ROM_ST_WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = req_we_q;
          mem_addr_d  = {req_tag_q, 2'b00};
          mem_wdata_d = req_wdata_q;
          cnt_d       = '0;
        end
      end
      ROM_ST_FETCH: begin
        if (mem_ready) begin
          buf_fill   = 1'b1;
          mem_req_d  = 1'b0;
          req_done_d = 1'b1;
          state_d    = ROM_ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Abort: hand back a NOP and leave the buffer untouched.
          mem_req_d  = 1'b0;
          bus_err_d  = 1'b1;
          req_done_d = 1'b1;
          rd_d       = NOP_WORD;
          state_d    = ROM_ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ROM_ST_WRITE: begin
        if (mem_ready) begin
          buf_wr     = 1'b1;
          mem_req_d  = 1'b0;
          mem_we_d   = '0;
          req_done_d = 1'b1;
          if (buf_hit) rd_d = buf_merged;
          state_d    = ROM_ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d  = 1'b0;
          mem_we_d   = '0;
          bus_err_d  = 1'b1;
          req_done_d = 1'b1;
          state_d    = ROM_ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ROM_ST_IDLE;
    endcase

    // Request capture only while not stalling, so req_* stay frozen during a stall.
    if (!rom_stall) begin
      if (rom_en) begin
        req_valid_d = 1'b1;
        req_done_d  = 1'b0;
        req_tag_d   = rom_addr[ADDR_W-1:2];
        req_we_d    = rom_write_en;
        req_wdata_d = rom_write_data;
      end else begin
        req_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ROM_ST_IDLE;
      req_valid_q <= 1'b0;
      req_done_q  <= 1'b0;
      req_tag_q   <= '0;
      req_we_q    <= '0;
      req_wdata_q <= '0;
      cnt_q       <= '0;
      rd_q        <= '0;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_done_q  <= req_done_d;
      req_tag_q   <= req_tag_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      bus_err_q   <= bus_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_rom_responder.sv
// Scoreboard bench for rom_responder: stimulus pushes expected read words and backing
// transactions; monitors pop and compare whenever the DUT presents them.
module tb_rom_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_en = 1'b0;
  logic [3:0]  rom_write_en = 4'h0;
  logic [31:0] rom_addr = 32'h0;
  logic [31:0] rom_write_data = 32'h0;
  logic [31:0] rom_read_data;
  logic        rom_stall;
  logic        bus_err;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_data[$];
  logic [67:0] exp_mem[$];
  int          resp_delay = 0;
  logic [31:0] resp_word = 32'h0;
  int          req_cycles = 0;
  logic        pending = 1'b0;
  int          st;

  assign mem_rdata = resp_word;

  always #5 clk = ~clk;

  rom_responder #(.TIMEOUT_CYCLES(8), .NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .rom_en(rom_en), .rom_write_en(rom_write_en),
    .rom_addr(rom_addr), .rom_write_data(rom_write_data), .rom_read_data(rom_read_data),
    .rom_stall(rom_stall), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Backing memory: ready on the resp_delay-th cycle of mem_req (0 = never).
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      req_cycles++;
      mem_ready = (resp_delay != 0) && (req_cycles == resp_delay);
    end else begin
      req_cycles = 0;
      mem_ready  = 1'b0;
    end
  end

  // Monitor: backing handshakes and read responses, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      pending = 1'b0;
    end else begin
      if (mem_req && mem_ready) begin
        if (exp_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_txn: got unexpected %h %h %h", mem_addr, mem_we, mem_wdata);
        end else begin
          chk("mem_txn", {mem_addr, mem_we, mem_wdata}, exp_mem.pop_front());
        end
      end
      if (pending && !rom_stall) begin
        pending = 1'b0;
        if (exp_data.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_data: got unexpected %h", rom_read_data);
        end else begin
          chk("rd_data", 68'(rom_read_data), 68'(exp_data.pop_front()));
        end
      end
      if (rom_en && !rom_stall) pending = 1'b1;
    end
  end

  task automatic do_req(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                        input int dly, input logic [31:0] word, output int stalls);
    int guard;
    resp_delay     = dly;
    resp_word      = word;
    rom_en         = 1'b1;
    rom_addr       = a;
    rom_write_en   = we;
    rom_write_data = wd;
    @(posedge clk); #1;
    stalls = 0;
    guard  = 0;
    while (rom_stall && guard < 100) begin
      @(posedge clk); #1;
      stalls++;
      guard++;
    end
    if (rom_stall) begin
      checks++; errors++;
      $display("FAIL req_wait: got stall still high expected release for addr %h", a);
    end
    rom_en = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_ctl", {rom_read_data, rom_stall, bus_err, mem_req}, 68'h0);
    chk("reset_mem", {mem_we, mem_addr, mem_wdata}, 68'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Miss then hit
    exp_mem.push_back({32'hBFC0_0000, 4'h0, 32'h0});
    exp_data.push_back(32'h3C08_0001);
    do_req(32'hBFC0_0000, 4'h0, 32'h0, 3, 32'h3C08_0001, st);
    chk("t1_stall_cycles", 68'(st), 68'd4);

    // Repeat same address: buffer hit, no backing access
    exp_data.push_back(32'h3C08_0001);
    do_req(32'hBFC0_0000, 4'h0, 32'h0, 3, 32'hDEAD_BEEF, st);
    chk("t2_stall_cycles", 68'(st), 68'd0);
    chk("t2_no_mem_req", 68'(mem_req), 68'd0);

    // Partial write to buffered word, then read back merged word
    exp_mem.push_back({32'hBFC0_0000, 4'b0011, 32'h0000_ABCD});
    exp_data.push_back(32'h3C08_ABCD);
    do_req(32'hBFC0_0000, 4'b0011, 32'h0000_ABCD, 2, 32'h0, st);
    chk("t3_write_stall", 68'(st), 68'd3);
    exp_data.push_back(32'h3C08_ABCD);
    do_req(32'hBFC0_0000, 4'h0, 32'h0, 2, 32'h0, st);
    chk("t3_read_stall", 68'(st), 68'd0);

    // Timeout: one miss cycle plus 8 unanswered FETCH cycles
    exp_data.push_back(32'h0000_0000);
    do_req(32'hBFC0_0010, 4'h0, 32'h0, 0, 32'h1111_1111, st);
    chk("t4_stall_cycles", 68'(st), 68'd9);
    chk("t4_bus_err_hi", 68'(bus_err), 68'd1);
    chk("t4_mem_req_lo", 68'(mem_req), 68'd0);
    @(posedge clk); #1;
    chk("t4_bus_err_pulse", 68'(bus_err), 68'd0);

    // Write to an unbuffered word: read data holds the NOP
    exp_mem.push_back({32'h0000_1000, 4'hF, 32'h1122_3344});
    exp_data.push_back(32'h0000_0000);
    do_req(32'h0000_1000, 4'hF, 32'h1122_3344, 1, 32'h0, st);
    chk("t4b_write_stall", 68'(st), 68'd2);

    // Byte offset ignored: still a hit on the untouched buffer
    exp_data.push_back(32'h3C08_ABCD);
    do_req(32'hBFC0_0003, 4'h0, 32'h0, 1, 32'h0, st);
    chk("t4c_offset_hit", 68'(st), 68'd0);

    // Reset mid-FETCH
    resp_delay   = 0;
    rom_en       = 1'b1;
    rom_addr     = 32'hBFC0_0020;
    rom_write_en = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_req_before_rst", 68'(mem_req), 68'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_clear", {mem_req, rom_stall, rom_read_data}, 68'h0);
    rom_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_mem.push_back({32'hBFC0_0000, 4'h0, 32'h0});
    exp_data.push_back(32'h3C08_0001);
    do_req(32'hBFC0_0000, 4'h0, 32'h0, 1, 32'h3C08_0001, st);
    chk("t5_miss_after_rst", 68'(st), 68'd2);

    // Idle port: nothing moves, data holds
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t6_idle_hold", {mem_req, rom_stall, rom_read_data}, {34'h0, 32'h3C08_0001});
    end

    chk("exp_data_left", 68'(exp_data.size()), 68'd0);
    chk("exp_mem_left", 68'(exp_mem.size()), 68'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule
